// File: rtl/regbank_access_seq.sv
// rtl/regbank_access_seq.sv - read/write access sequencer owning all register_bank controls
// Arbitrates read and write requests onto the bank's single rw port and returns read operands.
module regbank_access_seq #(
  parameter int DATA_W        = 8,
  parameter int IDX_W         = 3,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [IDX_W-1:0]  rd_req_ia,
  input  logic [IDX_W-1:0]  rd_req_ib,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_rsp_a,
  output logic [DATA_W-1:0] rd_rsp_b,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [IDX_W-1:0]  wr_req_idx,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              bank_rw,
  output logic [IDX_W-1:0]  bank_ri_a,
  output logic [IDX_W-1:0]  bank_ri_b,
  output logic [IDX_W-1:0]  bank_ri_d,
  output logic [DATA_W-1:0] bank_d,
  input  logic [DATA_W-1:0] bank_a,
  input  logic [DATA_W-1:0] bank_b,
  output logic              busy
);

  localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RD_CAP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_nxt;

  logic                r_bank_rw;
  logic [IDX_W-1:0]    r_bank_ri_a;
  logic [IDX_W-1:0]    r_bank_ri_b;
  logic [IDX_W-1:0]    r_bank_ri_d;
  logic [DATA_W-1:0]   r_bank_d;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_a;
  logic [DATA_W-1:0]   r_rsp_b;
  logic                r_busy;

  logic                w_can_grant;
  logic                w_streak_full;
  logic                w_wr_grant;
  logic                w_rd_grant;

  // RD_WAIT must keep rw low and indices stable while the bank samples them
  assign w_can_grant   = (r_state != RD_WAIT);
  assign w_streak_full = (r_streak == STREAK_W'(MAX_WR_STREAK));
  assign w_wr_grant    = w_can_grant && wr_req_valid && !(rd_req_valid && w_streak_full);
  assign w_rd_grant    = w_can_grant && rd_req_valid && !w_wr_grant;

  assign wr_req_ready  = w_wr_grant;
  assign rd_req_ready  = w_rd_grant;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_WAIT: w_state_nxt = RD_CAP;
      default: begin
        if (w_wr_grant) begin
          w_state_nxt = WR;
        end else if (w_rd_grant) begin
          w_state_nxt = RD_WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // Streak only counts writes that overtook a waiting read
  always_comb begin
    w_streak_nxt = r_streak;
    if (w_rd_grant || !rd_req_valid) begin
      w_streak_nxt = '0;
    end else if (w_wr_grant && !w_streak_full) begin
      w_streak_nxt = r_streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_rw   <= 1'b0;
      r_bank_ri_a <= '0;
      r_bank_ri_b <= '0;
      r_bank_ri_d <= '0;
      r_bank_d    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_a     <= '0;
      r_rsp_b     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_bank_rw   <= w_wr_grant;
      r_rsp_valid <= (r_state == RD_CAP);
      r_busy      <= (w_state_nxt != IDLE);
      if (w_wr_grant) begin
        r_bank_ri_d <= wr_req_idx;
        r_bank_d    <= wr_req_data;
      end
      if (w_rd_grant) begin
        r_bank_ri_a <= rd_req_ia;
        r_bank_ri_b <= rd_req_ib;
      end
      // Bank outputs became valid on the RD_WAIT->RD_CAP edge
      if (r_state == RD_CAP) begin
        r_rsp_a <= bank_a;
        r_rsp_b <= bank_b;
      end
    end
  end

  assign bank_rw      = r_bank_rw;
  assign bank_ri_a    = r_bank_ri_a;
  assign bank_ri_b    = r_bank_ri_b;
  assign bank_ri_d    = r_bank_ri_d;
  assign bank_d       = r_bank_d;
  assign rd_rsp_valid = r_rsp_valid;
  assign rd_rsp_a     = r_rsp_a;
  assign rd_rsp_b     = r_rsp_b;
  assign busy         = r_busy;

endmodule

// File: tb/tb_regbank_access_seq.sv
// tb/tb_regbank_access_seq.sv - self-checking bench for regbank_access_seq
// Transaction-level model of grants, bank contents and responses checked every cycle.
module tb_regbank_access_seq;
  localparam int DW   = 8;
  localparam int IW   = 3;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req_valid, rd_req_ready;
  logic [IW-1:0] rd_req_ia, rd_req_ib;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_a, rd_rsp_b;
  logic          wr_req_valid, wr_req_ready;
  logic [IW-1:0] wr_req_idx;
  logic [DW-1:0] wr_req_data;
  logic          bank_rw;
  logic [IW-1:0] bank_ri_a, bank_ri_b, bank_ri_d;
  logic [DW-1:0] bank_d, bank_a, bank_b;
  logic          busy;

  always #5 clk = ~clk;

  regbank_access_seq #(.DATA_W(DW), .IDX_W(IW), .MAX_WR_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_ia(rd_req_ia), .rd_req_ib(rd_req_ib),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_a(rd_rsp_a), .rd_rsp_b(rd_rsp_b),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_idx(wr_req_idx), .wr_req_data(wr_req_data),
    .bank_rw(bank_rw), .bank_ri_a(bank_ri_a), .bank_ri_b(bank_ri_b),
    .bank_ri_d(bank_ri_d), .bank_d(bank_d), .bank_a(bank_a), .bank_b(bank_b),
    .busy(busy)
  );

  // Register bank: write on rw, registered read ports
  logic          bank_preload;
  logic [DW-1:0] bank_mem [8];
  always @(posedge clk) begin
    if (bank_preload) begin
      for (int i = 0; i < 8; i++) bank_mem[i] <= 8'(i * 29 + 7);
    end else if (bank_rw) begin
      bank_mem[bank_ri_d] <= bank_d;
    end
    bank_a <= bank_mem[bank_ri_a];
    bank_b <= bank_mem[bank_ri_b];
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            due;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } rsp_t;

  logic [DW-1:0] m_regs [8];
  int            m_streak;
  bit            m_blocked;
  logic          m_rw, m_rsp_v, m_busy;
  logic [IW-1:0] m_ri_a, m_ri_b, m_ri_d;
  logic [DW-1:0] m_d, m_rsp_a, m_rsp_b;
  rsp_t          m_q[$];
  int            edge_no = 0;

  logic          o_wr_g, o_rd_g, o_rsp_v;
  logic [DW-1:0] o_rsp_a, o_rsp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_streak = 0; m_blocked = 0; m_rw = 0; m_rsp_v = 0; m_busy = 0;
    m_ri_a = 0; m_ri_b = 0; m_ri_d = 0; m_d = 0; m_rsp_a = 0; m_rsp_b = 0;
    m_q.delete();
  endtask

  // One cycle: drive inputs, compare DUT against model, then advance model past the next edge
  task automatic step(input bit rv, input logic [IW-1:0] ia, input logic [IW-1:0] ib,
                      input bit wv, input logic [IW-1:0] widx, input logic [DW-1:0] wdata);
    bit   wg, rg;
    rsp_t r;
    @(negedge clk);
    rd_req_valid = rv; rd_req_ia = ia; rd_req_ib = ib;
    wr_req_valid = wv; wr_req_idx = widx; wr_req_data = wdata;
    #1;
    wg = !m_blocked && wv && !(rv && m_streak == MAXS);
    rg = !m_blocked && rv && !wg;
    chk("wr_req_ready", wr_req_ready, wg);
    chk("rd_req_ready", rd_req_ready, rg);
    chk("bank_rw", bank_rw, m_rw);
    chk("bank_ri_d", bank_ri_d, m_ri_d);
    chk("bank_d", bank_d, m_d);
    chk("bank_ri_a", bank_ri_a, m_ri_a);
    chk("bank_ri_b", bank_ri_b, m_ri_b);
    chk("rd_rsp_valid", rd_rsp_valid, m_rsp_v);
    chk("rd_rsp_a", rd_rsp_a, m_rsp_a);
    chk("rd_rsp_b", rd_rsp_b, m_rsp_b);
    chk("busy", busy, m_busy);
    o_wr_g = wr_req_ready; o_rd_g = rd_req_ready;
    o_rsp_v = rd_rsp_valid; o_rsp_a = rd_rsp_a; o_rsp_b = rd_rsp_b;

    if (rg || !rv) m_streak = 0;
    else if (wg && m_streak < MAXS) m_streak++;
    m_busy    = wg || rg || m_blocked;
    m_blocked = rg;
    m_rw      = wg;
    if (wg) begin
      m_ri_d = widx; m_d = wdata; m_regs[widx] = wdata;
    end
    if (rg) begin
      m_ri_a = ia; m_ri_b = ib;
      r.due = edge_no + 2; r.a = m_regs[ia]; r.b = m_regs[ib];
      m_q.push_back(r);
    end
    m_rsp_v = 0;
    if (m_q.size() > 0 && m_q[0].due == edge_no) begin
      m_rsp_v = 1; m_rsp_a = m_q[0].a; m_rsp_b = m_q[0].b;
      void'(m_q.pop_front());
    end
    edge_no++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_rsp(output int n, output logic [DW-1:0] a, output logic [DW-1:0] b);
    bit got = 0;
    n = 0; a = 0; b = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (o_rsp_v) begin
        got = 1; n = i; a = o_rsp_a; b = o_rsp_b;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL wait_rsp: got no rd_rsp_valid expected one within 8 cycles");
    end
  endtask

  int            n, cnt;
  logic [DW-1:0] ra, rb;
  string         grants;

  initial begin
    rst_n = 0; bank_preload = 1;
    rd_req_valid = 0; rd_req_ia = 0; rd_req_ib = 0;
    wr_req_valid = 0; wr_req_idx = 0; wr_req_data = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'(i * 29 + 7);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset bank_rw", bank_rw, 0);
    chk("reset bank_ri_a", bank_ri_a, 0);
    chk("reset bank_ri_d", bank_ri_d, 0);
    chk("reset bank_d", bank_d, 0);
    chk("reset rd_rsp_valid", rd_rsp_valid, 0);
    chk("reset rd_rsp_a", rd_rsp_a, 0);
    chk("reset busy", busy, 0);
    chk("reset readys", {rd_req_ready, wr_req_ready}, 0);
    rst_n = 1; bank_preload = 0;
    model_reset();

    // Write r3 then read (3,3)
    step(0, 0, 0, 1, 3, 8'hA5);
    step(1, 3, 3, 0, 0, 0);
    chk("raw33 read granted", o_rd_g, 1);
    wait_rsp(n, ra, rb);
    chk("raw33 latency", n, 3);
    chk("raw33 a", ra, 8'hA5);
    chk("raw33 b", rb, 8'hA5);

    // Read presented the cycle after the write
    step(0, 0, 0, 1, 5, 8'h3C);
    step(1, 5, 0, 0, 0, 0);
    wait_rsp(n, ra, rb);
    chk("raw50 a", ra, 8'h3C);

    // Streak arbitration with both valids held
    idle(1);
    grants = "";
    for (int i = 0; i < 12; i++) begin
      step(1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1, 3'($urandom_range(0, 7)), 8'($urandom));
      if (o_wr_g) grants = {grants, "W"};
      if (o_rd_g) grants = {grants, "R"};
    end
    total++;
    if (grants != "WWWWRWWWWR") begin
      bad++;
      $display("FAIL streak order: got %s expected WWWWRWWWWR", grants);
    end
    idle(4);

    // Back-to-back writes then crossed reads
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 3'(i), 8'(i * 17));
      if (o_wr_g) cnt++;
    end
    chk("b2b write grants", cnt, 8);
    step(1, 0, 7, 0, 0, 0);
    wait_rsp(n, ra, rb);
    chk("rd07 a", ra, 8'h00);
    chk("rd07 b", rb, 8'h77);
    step(1, 1, 6, 0, 0, 0);
    wait_rsp(n, ra, rb);
    chk("rd16 a", ra, 8'h11);
    chk("rd16 b", rb, 8'h66);

    // Write waits out RD_WAIT
    step(1, 2, 4, 0, 0, 0);
    step(0, 0, 0, 1, 6, 8'h5A);
    chk("rdwait wr_ready", o_wr_g, 0);
    chk("rdwait rd_ready", o_rd_g, 0);
    chk("rdwait ri_a", bank_ri_a, 2);
    chk("rdwait ri_b", bank_ri_b, 4);
    step(0, 0, 0, 1, 6, 8'h5A);
    chk("after rdwait wr_ready", o_wr_g, 1);
    idle(4);

    // Reset while in RD_WAIT
    step(1, 1, 2, 0, 0, 0);
    @(negedge clk);
    rst_n = 0; rd_req_valid = 0; wr_req_valid = 0;
    #1;
    chk("midrst bank_rw", bank_rw, 0);
    chk("midrst busy", busy, 0);
    chk("midrst rsp_valid", rd_rsp_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (o_rsp_v) cnt++;
    end
    chk("midrst no response", cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int pr = (i / 500) % 2 == 0 ? 50 : 85;
      step($urandom_range(0, 99) < pr, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           $urandom_range(0, 99) < pr, 3'($urandom_range(0, 7)), 8'($urandom));
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
